// File: rtl/drum_envelope_pkg.sv
// Shared types and constants for the drum voice amplitude envelope.
// Contents: envelope FSM state enum, sample/envelope constants, and the
// saturating 8-bit add/subtract helpers used for envelope stepping.
package drum_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY
  } env_state_t;

  localparam logic [7:0] SAMPLE_MID = 8'h80;
  localparam logic [7:0] ENV_MAX    = 8'hFF;

  // 9-bit sum, clamp at ENV_MAX on carry out.
  function automatic logic [7:0] env_sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? ENV_MAX : sum[7:0];
  endfunction

  // 9-bit signed difference, clamp at zero when it goes negative.
  function automatic logic [7:0] env_sat_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[8] ? 8'h00 : diff[7:0];
  endfunction

endpackage

// File: rtl/drum_envelope_env_scaler.sv
// Scales an offset-binary sample about the 0x80 midpoint by an 8-bit envelope.
// Ports: clk, reset (async, active-low); sample/env/valid in;
//        sample_out/sample_out_valid out (2-cycle latency, 1 sample/cycle).
module env_scaler
  import drum_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample,
  input  logic [7:0] env,
  input  logic       valid,
  output logic [7:0] sample_out,
  output logic       sample_out_valid
);

  logic signed [8:0]  s1;
  logic [7:0]         env1;
  logic               v1;

  logic signed [15:0] s_ext;
  logic signed [15:0] e_ext;
  logic signed [15:0] prod;
  logic signed [15:0] q;

  // Stage 1: recentre the sample and capture the envelope it is paired with.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= '0;
      env1 <= '0;
      v1   <= 1'b0;
    end else begin
      v1 <= valid;
      if (valid) begin
        s1   <= $signed({1'b0, sample}) - 9'sd128;
        env1 <= env;
      end
    end
  end

  // |s * env| <= 128*255, so a 16-bit signed product never overflows.
  assign s_ext = {{7{s1[8]}}, s1};
  assign e_ext = {8'h00, env1};
  assign prod  = s_ext * e_ext;
  assign q     = prod >>> 8;

  // Stage 2: q lies in -128..126, so re-adding the midpoint cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out       <= SAMPLE_MID;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= v1;
      if (v1) begin
        sample_out <= q[7:0] + SAMPLE_MID;
      end
    end
  end

endmodule

// File: rtl/drum_envelope.sv
// Drum hit amplitude envelope: attack/decay FSM with tick divider, feeding a
// 2-stage sample scaler. Ports: clk, reset (async, active-low), trig,
// sample_in/sample_valid in; sample_out/sample_out_valid, env, busy out.
module drum_envelope
  import drum_pkg::*;
#(
  parameter int unsigned ATTACK_STEP = 16,
  parameter int unsigned DECAY_STEP  = 1,
  parameter int unsigned TICK_DIV    = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic [7:0] sample_out,
  output logic       sample_out_valid,
  output logic [7:0] env,
  output logic       busy
);

  localparam int unsigned      CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       ATK      = 8'(ATTACK_STEP);
  localparam logic [7:0]       DCY      = 8'(DECAY_STEP);

  env_state_t       state;
  env_state_t       state_next;
  logic             busy_r;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] count_wrap;
  logic [7:0]       env_lvl;
  logic [7:0]       env_next;
  logic [7:0]       env_up;
  logic [7:0]       env_dn;
  logic             tick;

  assign tick       = (state != ENV_IDLE) && (count == CNT_LAST);
  assign count_wrap = tick ? '0 : count + 1'b1;
  assign env_up     = env_sat_add(env_lvl, ATK);
  assign env_dn     = env_sat_sub(env_lvl, DCY);

  // State register; busy is registered from the next state so it moves on
  // the same edge as the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ENV_IDLE;
      busy_r <= 1'b0;
    end else begin
      state  <= state_next;
      busy_r <= (state_next != ENV_IDLE);
    end
  end

  // Next-state logic. A retrigger in DECAY takes priority over a coincident
  // tick, so the envelope never drops to IDLE on the edge it is re-hit.
  always_comb begin
    state_next = state;
    unique case (state)
      ENV_IDLE: begin
        if (trig) state_next = ENV_ATTACK;
      end
      ENV_ATTACK: begin
        if (tick && env_up == ENV_MAX) state_next = ENV_DECAY;
      end
      ENV_DECAY: begin
        if (trig)                     state_next = ENV_ATTACK;
        else if (tick && env_dn == '0) state_next = ENV_IDLE;
      end
      default: state_next = ENV_IDLE;
    endcase
  end

  // Envelope level and tick counter updates.
  always_comb begin
    env_next   = env_lvl;
    count_next = count;
    unique case (state)
      ENV_IDLE: begin
        env_next   = '0;
        count_next = '0;
      end
      ENV_ATTACK: begin
        count_next = count_wrap;
        if (tick) env_next = env_up;
      end
      ENV_DECAY: begin
        if (trig) begin
          // Re-attack from the current level with a fresh tick period.
          count_next = '0;
        end else begin
          count_next = count_wrap;
          if (tick) env_next = env_dn;
        end
      end
      default: begin
        env_next   = '0;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      env_lvl <= '0;
      count   <= '0;
    end else begin
      env_lvl <= env_next;
      count   <= count_next;
    end
  end

  assign env  = env_lvl;
  assign busy = busy_r;

  env_scaler u_scaler (
    .clk              (clk),
    .reset            (reset),
    .sample           (sample_in),
    .env              (env_lvl),
    .valid            (sample_valid),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid)
  );

endmodule

// File: tb/tb_drum_envelope.sv
// Directed bench for drum_envelope with TICK_DIV=4, ATTACK_STEP=64, DECAY_STEP=128.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_drum_envelope;

  logic       clk;
  logic       reset;
  logic       trig;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [7:0] sample_out;
  logic       sample_out_valid;
  logic [7:0] env;
  logic       busy;

  int n_checks;
  int n_fail;

  drum_envelope #(
    .ATTACK_STEP (64),
    .DECAY_STEP  (128),
    .TICK_DIV    (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .trig             (trig),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .env              (env),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to just after the given edge number of the current hit.
  task automatic step_to(inout int e, input int target);
    while (e < target) begin
      step();
      e++;
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sample_in = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      trig = i[0];
      sample_valid = ~i[0];
      step();
      n_checks++;
      if (sample_out !== 8'h80 || sample_out_valid !== 1'b0 || env !== 8'h00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: out=%h vld=%b env=%h busy=%b, want out=80 vld=0 env=00 busy=0",
                 i, sample_out, sample_out_valid, env, busy);
      end
    end
    trig = 1'b0;
    sample_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (env !== 8'h00 || busy !== 1'b0 || sample_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: env=%h busy=%b vld=%b, want env=00 busy=0 vld=0",
               env, busy, sample_out_valid);
    end
  endtask

  task automatic test_full_hit();
    logic [7:0] lvl [7];
    int e;
    lvl = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd255, 8'd127, 8'd0};
    e = 0;
    pulse_trig();
    n_checks++;
    if (busy !== 1'b1 || env !== 8'h00) begin
      n_fail++;
      $display("FAIL hit_start: busy=%b env=%h, want busy=1 env=00", busy, env);
    end
    for (int n = 1; n <= 24; n++) begin
      step();
      n_checks++;
      if (env !== lvl[n / 4] || busy !== (n < 24)) begin
        n_fail++;
        $display("FAIL hit_edge[%0d]: env=%h busy=%b, want env=%h busy=%b",
                 n, env, busy, lvl[n / 4], (n < 24));
      end
    end
    step_to(e, 0);
  endtask

  task automatic test_scaling();
    int e;
    // env 0 while idle: any sample collapses to the midpoint.
    sample_in = 8'hFF;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    n_checks++;
    if (sample_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL scale_env0_early: vld=%b, want 0", sample_out_valid);
    end
    step();
    n_checks++;
    if (sample_out_valid !== 1'b1 || sample_out !== 8'h80) begin
      n_fail++;
      $display("FAIL scale_env0: vld=%b out=%h, want vld=1 out=80", sample_out_valid, sample_out);
    end
    step();
    n_checks++;
    if (sample_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL scale_env0_single: vld=%b, want 0", sample_out_valid);
    end

    // env 128 holds after edges 8..11 of a hit.
    e = 0;
    pulse_trig();
    step_to(e, 8);
    sample_in = 8'hC0;
    sample_valid = 1'b1;
    step(); e++;
    sample_valid = 1'b0;
    step(); e++;
    n_checks++;
    if (sample_out_valid !== 1'b1 || sample_out !== 8'hA0) begin
      n_fail++;
      $display("FAIL scale_env128: vld=%b out=%h, want vld=1 out=a0", sample_out_valid, sample_out);
    end

    // env 255 holds after edges 16..19; two back-to-back samples.
    step_to(e, 16);
    sample_in = 8'hFF;
    sample_valid = 1'b1;
    step(); e++;
    sample_in = 8'h00;
    n_checks++;
    if (sample_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL scale_b2b_early: vld=%b, want 0", sample_out_valid);
    end
    step(); e++;
    sample_valid = 1'b0;
    n_checks++;
    if (sample_out_valid !== 1'b1 || sample_out !== 8'hFE) begin
      n_fail++;
      $display("FAIL scale_env255_ff: vld=%b out=%h, want vld=1 out=fe", sample_out_valid, sample_out);
    end
    step(); e++;
    n_checks++;
    if (sample_out_valid !== 1'b1 || sample_out !== 8'h00) begin
      n_fail++;
      $display("FAIL scale_env255_00: vld=%b out=%h, want vld=1 out=00", sample_out_valid, sample_out);
    end
    step(); e++;
    n_checks++;
    if (sample_out_valid !== 1'b0 || sample_out !== 8'h00) begin
      n_fail++;
      $display("FAIL scale_hold: vld=%b out=%h, want vld=0 out=00", sample_out_valid, sample_out);
    end
    step_to(e, 26);
    n_checks++;
    if (busy !== 1'b0 || env !== 8'h00) begin
      n_fail++;
      $display("FAIL scale_hit_end: busy=%b env=%h, want busy=0 env=00", busy, env);
    end
  endtask

  task automatic test_retrigger();
    int e;
    e = 0;
    pulse_trig();
    step_to(e, 21);
    n_checks++;
    if (env !== 8'd127 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL retrig_pre: env=%0d busy=%b, want env=127 busy=1", env, busy);
    end
    pulse_trig(); e++;                 // edge 22: back to ATTACK, counter cleared
    n_checks++;
    if (env !== 8'd127 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL retrig_hold: env=%0d busy=%b, want env=127 busy=1", env, busy);
    end
    step_to(e, 25);
    n_checks++;
    if (env !== 8'd127) begin
      n_fail++;
      $display("FAIL retrig_cnt_clear: env=%0d, want 127", env);
    end
    step_to(e, 26);
    n_checks++;
    if (env !== 8'd191) begin
      n_fail++;
      $display("FAIL retrig_tick1: env=%0d, want 191", env);
    end
    pulse_trig(); e++;                 // edge 27: ignored in ATTACK
    step_to(e, 29);
    n_checks++;
    if (env !== 8'd191 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL attack_trig_ignored: env=%0d busy=%b, want env=191 busy=1", env, busy);
    end
    step_to(e, 30);
    n_checks++;
    if (env !== 8'd255) begin
      n_fail++;
      $display("FAIL retrig_peak: env=%0d, want 255", env);
    end
    step_to(e, 34);
    n_checks++;
    if (env !== 8'd127) begin
      n_fail++;
      $display("FAIL retrig_decay: env=%0d, want 127", env);
    end
  endtask

  // Continues the hit left by test_retrigger: env 127 in DECAY after edge 34.
  task automatic test_trig_on_tick();
    int e;
    e = 34;
    step_to(e, 37);
    pulse_trig(); e++;                 // edge 38 carries a decay tick too
    n_checks++;
    if (env !== 8'd127 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL trig_tick_hold: env=%0d busy=%b, want env=127 busy=1", env, busy);
    end
    step_to(e, 41);
    n_checks++;
    if (env !== 8'd127) begin
      n_fail++;
      $display("FAIL trig_tick_wait: env=%0d, want 127", env);
    end
    step_to(e, 42);
    n_checks++;
    if (env !== 8'd191) begin
      n_fail++;
      $display("FAIL trig_tick_attack: env=%0d, want 191", env);
    end
  endtask

  // Continues the hit: env reaches 255 at edge 46 and starts decaying.
  task automatic test_async_reset();
    int e;
    e = 42;
    step_to(e, 47);
    sample_in = 8'hFF;
    sample_valid = 1'b1;
    step(); e++;                       // edge 48 captures a sample at env 255
    sample_valid = 1'b0;
    n_checks++;
    if (env !== 8'd255 || busy !== 1'b1 || sample_out !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_pre: env=%0d busy=%b out=%h, want env=255 busy=1 out=00", env, busy, sample_out);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (env !== 8'h00 || busy !== 1'b0 || sample_out !== 8'h80 || sample_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: env=%h busy=%b out=%h vld=%b, want 00 0 80 0",
               env, busy, sample_out, sample_out_valid);
    end
    step();
    n_checks++;
    if (sample_out_valid !== 1'b0 || sample_out !== 8'h80) begin
      n_fail++;
      $display("FAIL areset_pipe_abort: vld=%b out=%h, want vld=0 out=80", sample_out_valid, sample_out);
    end
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (sample_out_valid !== 1'b0 || busy !== 1'b0 || env !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_after: vld=%b busy=%b env=%h, want 0 0 00", sample_out_valid, busy, env);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    trig = 1'b0;
    sample_in = 8'h80;
    sample_valid = 1'b0;
    test_reset();
    test_full_hit();
    test_scaling();
    test_retrigger();
    test_trig_on_tick();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
